// File: rtl/seg7_pkg.sv
// Shared types and the hex-to-segment table for the 4-digit 7-segment scan controller.
package seg7_pkg;

    // Scan phase within one digit slot: all-off gap, then the lit digit.
    typedef enum logic [0:0] {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } scan_state_t;

    // Display word: per-digit decimal points on top, four hex nibbles below.
    typedef struct packed {
        logic [3:0]  dp;
        logic [15:0] data;
    } disp_word_t;

    localparam logic [19:0] DISP_WORD_CLEAR = 20'h0_0000;

    // Active-high g..a pattern for one hex nibble.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
        logic [6:0] seg;
        case (nibble)
            4'h0:    seg = 7'h3F;
            4'h1:    seg = 7'h06;
            4'h2:    seg = 7'h5B;
            4'h3:    seg = 7'h4F;
            4'h4:    seg = 7'h66;
            4'h5:    seg = 7'h6D;
            4'h6:    seg = 7'h7D;
            4'h7:    seg = 7'h07;
            4'h8:    seg = 7'h7F;
            4'h9:    seg = 7'h6F;
            4'hA:    seg = 7'h77;
            4'hB:    seg = 7'h7C;
            4'hC:    seg = 7'h39;
            4'hD:    seg = 7'h5E;
            4'hE:    seg = 7'h79;
            4'hF:    seg = 7'h71;
            default: seg = 7'h00;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational nibble + decimal point to active-high {dp, g..a} pattern.
module seg7_hex_decode (
    input  logic [3:0] nibble_i,
    input  logic       dp_i,
    output logic [7:0] pattern_o
);
    import seg7_pkg::*;

    // Look up the segment pattern and place the decimal point on bit 7.
    always_comb begin
        pattern_o = {dp_i, hex_to_seg(nibble_i)};
    end

endmodule

// File: rtl/seg7_scan_controller.sv
// Time-multiplexed 4-digit 7-segment scan controller with a double-buffered
// display word that is only swapped at frame boundaries, and a blanking gap
// at the start of every digit slot to suppress ghosting.
module seg7_scan_controller #(
    parameter int unsigned DIVIDER          = 131072,
    parameter int unsigned BLANK_CYCLES     = 1024,
    parameter bit          SEG_ACTIVE_LOW   = 1'b1,
    parameter bit          DIGIT_ACTIVE_LOW = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic        load,
    input  logic [15:0] dataIn,
    input  logic [3:0]  dpIn,
    output logic [7:0]  segment,
    output logic [3:0]  digit,
    output logic        frameDone,
    output logic        updatePending
);
    import seg7_pkg::*;

    localparam int unsigned      CNT_W      = (DIVIDER > 32'd1) ? $clog2(DIVIDER) : 32'd1;
    localparam logic [CNT_W-1:0] LAST_CNT   = CNT_W'(DIVIDER - 32'd1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_CYCLES == 32'd0) ? 32'd0 : (BLANK_CYCLES - 32'd1));
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(32'd1);
    // With no blanking gap every slot (and every restart) begins directly in SHOW.
    localparam scan_state_t      START_STATE = (BLANK_CYCLES == 32'd0) ? SHOW : BLANK;
    localparam logic [7:0]       SEG_OFF    = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;
    localparam logic [3:0]       DIGIT_OFF  = DIGIT_ACTIVE_LOW ? 4'hF : 4'h0;

    scan_state_t      state_q, state_d;
    logic [1:0]       index_q, index_d;
    logic [CNT_W-1:0] count_q, count_d;
    disp_word_t       active_q, active_d;
    disp_word_t       shadow_q, shadow_d;
    logic             pending_q, pending_d;
    logic [7:0]       segment_q, segment_d;
    logic [3:0]       digit_q, digit_d;
    logic             frame_done_q, frame_done_d;

    logic             boundary_s;
    logic             commit_s;
    disp_word_t       load_word_s;
    logic [3:0]       nibble_s;
    logic             dp_s;
    logic [7:0]       pattern_s;
    logic [3:0]       onehot_s;

    // Last SHOW cycle of digit 3 is the frame boundary; while disabled the
    // display is dark, so buffered data may be committed at any time.
    always_comb begin
        boundary_s  = enable && (state_q == SHOW) && (index_q == 2'd3) && (count_q == LAST_CNT);
        commit_s    = boundary_s || !enable;
        load_word_s = {dpIn, dataIn};
    end

    // Scan sequencer: BLANK gap, SHOW dwell, advance digit index at slot end.
    always_comb begin
        state_d = state_q;
        index_d = index_q;
        count_d = count_q;
        if (!enable) begin
            state_d = START_STATE;
            index_d = 2'd0;
            count_d = '0;
        end else begin
            case (state_q)
                BLANK: begin
                    count_d = count_q + CNT_ONE;
                    if (count_q == BLANK_LAST) begin
                        state_d = SHOW;
                    end else begin
                        state_d = BLANK;
                    end
                end
                SHOW: begin
                    if (count_q == LAST_CNT) begin
                        count_d = '0;
                        index_d = index_q + 2'd1;
                        state_d = START_STATE;
                    end else begin
                        count_d = count_q + CNT_ONE;
                    end
                end
                default: begin
                    state_d = START_STATE;
                    index_d = 2'd0;
                    count_d = '0;
                end
            endcase
        end
    end

    // Double buffer: loads land in the shadow and are promoted on commit; a
    // load coinciding with a commit goes straight to the active word.
    always_comb begin
        shadow_d  = shadow_q;
        active_d  = active_q;
        pending_d = pending_q;
        if (load) begin
            shadow_d = load_word_s;
            if (commit_s) begin
                active_d  = load_word_s;
                pending_d = 1'b0;
            end else begin
                pending_d = 1'b1;
            end
        end else if (commit_s && pending_q) begin
            active_d  = shadow_q;
            pending_d = 1'b0;
        end else begin
            pending_d = pending_q;
        end
    end

    // Pick the nibble and decimal point for the digit currently scanned.
    always_comb begin
        case (index_q)
            2'd0:    begin nibble_s = active_q.data[15:12]; dp_s = active_q.dp[0]; end
            2'd1:    begin nibble_s = active_q.data[11:8];  dp_s = active_q.dp[1]; end
            2'd2:    begin nibble_s = active_q.data[7:4];   dp_s = active_q.dp[2]; end
            2'd3:    begin nibble_s = active_q.data[3:0];   dp_s = active_q.dp[3]; end
            default: begin nibble_s = 4'h0;                 dp_s = 1'b0;           end
        endcase
        onehot_s = 4'b0001 << index_q;
    end

    seg7_hex_decode u_hex_decode (
        .nibble_i  (nibble_s),
        .dp_i      (dp_s),
        .pattern_o (pattern_s)
    );

    // Output stage: lit only in SHOW while enabled; polarity applied after decode.
    always_comb begin
        if (enable && (state_q == SHOW)) begin
            segment_d = SEG_ACTIVE_LOW ? ~pattern_s : pattern_s;
            digit_d   = DIGIT_ACTIVE_LOW ? ~onehot_s : onehot_s;
        end else begin
            segment_d = SEG_OFF;
            digit_d   = DIGIT_OFF;
        end
        frame_done_d = boundary_s;
    end

    // State, buffer and output registers; reset forces everything dark and clear.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= START_STATE;
            index_q      <= 2'd0;
            count_q      <= '0;
            active_q     <= DISP_WORD_CLEAR;
            shadow_q     <= DISP_WORD_CLEAR;
            pending_q    <= 1'b0;
            segment_q    <= SEG_OFF;
            digit_q      <= DIGIT_OFF;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            index_q      <= index_d;
            count_q      <= count_d;
            active_q     <= active_d;
            shadow_q     <= shadow_d;
            pending_q    <= pending_d;
            segment_q    <= segment_d;
            digit_q      <= digit_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign segment       = segment_q;
    assign digit         = digit_q;
    assign frameDone     = frame_done_q;
    assign updatePending = pending_q;

endmodule

// File: tb/tb_seg7_scan_controller.sv
// Directed bench: instance A (DIVIDER=8, BLANK_CYCLES=2) and instance B
// (DIVIDER=2, BLANK_CYCLES=0), both with active-low segments and strobes.
module tb_seg7_scan_controller;

    logic        clock = 1'b0;
    logic        reset_a, reset_b;
    logic        enable, load;
    logic [15:0] dataIn;
    logic [3:0]  dpIn;
    logic [7:0]  segment_a, segment_b;
    logic [3:0]  digit_a, digit_b;
    logic        frame_done_a, frame_done_b;
    logic        pending_a, pending_b;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    seg7_scan_controller #(
        .DIVIDER(8), .BLANK_CYCLES(2), .SEG_ACTIVE_LOW(1'b1), .DIGIT_ACTIVE_LOW(1'b1)
    ) dut_a (
        .clock(clock), .reset(reset_a), .enable(enable), .load(load),
        .dataIn(dataIn), .dpIn(dpIn), .segment(segment_a), .digit(digit_a),
        .frameDone(frame_done_a), .updatePending(pending_a)
    );

    seg7_scan_controller #(
        .DIVIDER(2), .BLANK_CYCLES(0), .SEG_ACTIVE_LOW(1'b1), .DIGIT_ACTIVE_LOW(1'b1)
    ) dut_b (
        .clock(clock), .reset(reset_b), .enable(enable), .load(load),
        .dataIn(dataIn), .dpIn(dpIn), .segment(segment_b), .digit(digit_b),
        .frameDone(frame_done_b), .updatePending(pending_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_off(input string tag, input bit sel);
        chk({tag, " seg"},  sel ? segment_b : segment_a, 32'hFF);
        chk({tag, " dig"},  sel ? digit_b : digit_a, 32'hF);
        chk({tag, " fd"},   sel ? frame_done_b : frame_done_a, 32'h0);
        chk({tag, " pend"}, sel ? pending_b : pending_a, 32'h0);
    endtask

    // Walk n samples of a frame (sample j reflects scan cycle j-1), checking
    // every output against the expected slot pattern; optionally load words
    // after samples la1/la2 so they are captured on the following edge.
    task automatic run_frame(input string name, input bit sel, input int slot_len,
                             input int blank_len, input int n,
                             input logic [7:0] s0, input logic [7:0] s1,
                             input logic [7:0] s2, input logic [7:0] s3,
                             input int la1, input logic [19:0] w1,
                             input int la2, input logic [19:0] w2);
        logic [7:0] sx [4];
        int         frame_len;
        sx[0] = s0; sx[1] = s1; sx[2] = s2; sx[3] = s3;
        frame_len = 4 * slot_len;
        for (int j = 1; j <= n; j++) begin
            int         slot, pos;
            logic [7:0] exp_seg;
            logic [3:0] exp_dig, oh;
            logic       exp_fd, exp_pend;
            @(posedge clock); #1;
            slot = (j - 1) / slot_len;
            pos  = (j - 1) % slot_len;
            oh   = 4'b0001 << slot;
            if (pos < blank_len) begin
                exp_seg = 8'hFF;
                exp_dig = 4'hF;
            end else begin
                exp_seg = sx[slot];
                exp_dig = ~oh;
            end
            exp_fd   = (j == frame_len);
            exp_pend = (la1 > 0) && (j > la1) && (j < frame_len);
            chk($sformatf("%s j%0d seg", name, j),  sel ? segment_b : segment_a, {24'h0, exp_seg});
            chk($sformatf("%s j%0d dig", name, j),  sel ? digit_b : digit_a, {28'h0, exp_dig});
            chk($sformatf("%s j%0d fd", name, j),   sel ? frame_done_b : frame_done_a, {31'h0, exp_fd});
            chk($sformatf("%s j%0d pend", name, j), sel ? pending_b : pending_a, {31'h0, exp_pend});
            if (j == la1) begin
                load = 1'b1; {dpIn, dataIn} = w1;
            end else if (j == la2) begin
                load = 1'b1; {dpIn, dataIn} = w2;
            end else begin
                load = 1'b0;
            end
        end
        load = 1'b0;
    endtask

    initial begin
        reset_a = 1'b1; reset_b = 1'b1;
        enable  = 1'b1; load = 1'b0;
        dataIn  = 16'h0000; dpIn = 4'h0;
        repeat (2) @(posedge clock);
        #1;
        chk_off("reset A", 1'b0);
        chk_off("reset B", 1'b1);
        reset_a = 1'b0;

        // Frame 0 still shows cleared data; 1234 is buffered during it.
        run_frame("A f0", 1'b0, 8, 2, 32, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 1, 20'h0_1234, 0, 20'h0);
        // Frame 1 shows 1234; AAAA then BEEF loaded mid-frame (last wins).
        run_frame("A f1", 1'b0, 8, 2, 32, 8'hF9, 8'hA4, 8'hB0, 8'h99, 3, 20'h0_AAAA, 10, 20'h0_BEEF);
        // Frame 2 shows BEEF; 0F00 loaded on the exact boundary cycle.
        run_frame("A f2", 1'b0, 8, 2, 32, 8'h83, 8'h86, 8'h86, 8'h8E, 31, 20'h0_0F00, 0, 20'h0);
        // Frame 3 shows 0F00; stop mid-SHOW of digit 2 and drop enable.
        run_frame("A f3", 1'b0, 8, 2, 20, 8'hC0, 8'h8E, 8'hC0, 8'hC0, 0, 20'h0, 0, 20'h0);
        enable = 1'b0;
        @(posedge clock); #1;
        chk_off("A disabled", 1'b0);
        enable = 1'b1;
        // Restart from digit 0 with the blanking gap first.
        run_frame("A reen", 1'b0, 8, 2, 32, 8'hC0, 8'h8E, 8'hC0, 8'hC0, 0, 20'h0, 0, 20'h0);
        // Partial frame with a pending load, then asynchronous reset mid-SHOW.
        run_frame("A pre", 1'b0, 8, 2, 5, 8'hC0, 8'h8E, 8'hC0, 8'hC0, 2, 20'h0_5555, 0, 20'h0);
        reset_a = 1'b1;
        #1;
        chk_off("A async rst", 1'b0);
        @(posedge clock); #1;
        reset_a = 1'b0;
        run_frame("A post", 1'b0, 8, 2, 32, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 0, 20'h0, 0, 20'h0);

        // Instance B: no gap, two cycles per digit, dp on digits 0 and 2.
        reset_b = 1'b0;
        run_frame("B f0", 1'b1, 2, 0, 8, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 1, 20'h5_1234, 0, 20'h0);
        run_frame("B f1", 1'b1, 2, 0, 8, 8'h79, 8'hA4, 8'h30, 8'h99, 0, 20'h0, 0, 20'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
